// File: rtl/fpu_stream_master_if.sv
// Host request/response and FPU unit strobe/ack signals for fpu_stream_master.
// The master modport is the stream master's view; slave is the host-plus-unit side.
interface fpu_stream_master_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] input_a;
    logic             input_a_stb;
    logic             input_a_ack;
    logic [WIDTH-1:0] input_b;
    logic             input_b_stb;
    logic             input_b_ack;
    logic [WIDTH-1:0] output_z;
    logic             output_z_stb;
    logic             output_z_ack;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_timeout;
    logic [15:0]      txn_count;

    modport master (
        input  req_valid, req_a, req_b, input_a_ack, input_b_ack,
               output_z, output_z_stb, rsp_ready,
        output req_ready, input_a, input_a_stb, input_b, input_b_stb,
               output_z_ack, rsp_valid, rsp_z, rsp_timeout, txn_count
    );

    modport slave (
        output req_valid, req_a, req_b, input_a_ack, input_b_ack,
               output_z, output_z_stb, rsp_ready,
        input  req_ready, input_a, input_a_stb, input_b, input_b_stb,
               output_z_ack, rsp_valid, rsp_z, rsp_timeout, txn_count
    );
endinterface

// File: rtl/fpu_stream_master.sv
// Drives one operand pair through an FPU unit's strobe/ack channels and returns
// the result (or a timeout indication) to the host on a valid/ready port.
//
// state    | meaning
// S_IDLE   | waiting for a host request, req_ready high
// S_SEND_A | presenting operand A until the unit acks it
// S_SEND_B | presenting operand B until the unit acks it
// S_WAIT_Z | ready for the result until the unit strobes it
// S_RESP   | holding the response until the host takes it
module fpu_stream_master #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    fpu_stream_master_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT_Z,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_stb_q;
    logic             b_stb_q;
    logic             z_ack_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_z_q;
    logic             rsp_tmo_q;
    logic [15:0]      txn_q;

    logic a_xfer, b_xfer, z_xfer, tmo_hit;

    assign a_xfer  = a_stb_q && bus.input_a_ack;
    assign b_xfer  = b_stb_q && bus.input_b_ack;
    assign z_xfer  = z_ack_q && bus.output_z_stb;
    assign tmo_hit = (timer_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_tmo_q   <= 1'b0;
            txn_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        timer_q <= '0;
                        a_stb_q <= 1'b1;
                        state_q <= S_SEND_A;
                    end
                end
                S_SEND_A, S_SEND_B, S_WAIT_Z: begin
                    timer_q <= timer_q + 1'b1;
                    // A completing transfer wins over a timeout on the same edge.
                    if (state_q == S_SEND_A && a_xfer) begin
                        a_stb_q <= 1'b0;
                        b_stb_q <= 1'b1;
                        state_q <= S_SEND_B;
                    end else if (state_q == S_SEND_B && b_xfer) begin
                        b_stb_q <= 1'b0;
                        z_ack_q <= 1'b1;
                        state_q <= S_WAIT_Z;
                    end else if (state_q == S_WAIT_Z && z_xfer) begin
                        rsp_z_q     <= bus.output_z;
                        rsp_tmo_q   <= 1'b0;
                        z_ack_q     <= 1'b0;
                        txn_q       <= txn_q + 16'd1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (tmo_hit) begin
                        a_stb_q     <= 1'b0;
                        b_stb_q     <= 1'b0;
                        z_ack_q     <= 1'b0;
                        rsp_z_q     <= '0;
                        rsp_tmo_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.input_a      = a_q;
    assign bus.input_b      = b_q;
    assign bus.input_a_stb  = a_stb_q;
    assign bus.input_b_stb  = b_stb_q;
    assign bus.output_z_ack = z_ack_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_z        = rsp_z_q;
    assign bus.rsp_timeout  = rsp_tmo_q;
    assign bus.txn_count    = txn_q;
endmodule

// File: doc/fpu_stream_master.md
# fpu_stream_master

Handshake master that drives the strobe/acknowledge operand interface of the FPU arithmetic units (adder first, same protocol for the others). It accepts an operand pair from a host-side valid/ready request port, presents operand A then operand B to the unit, collects the result, and returns it on a valid/ready response port. A cycle timeout ensures that a hung unit is reported to the host instead of stalling it.

## Interface
- WIDTH, 32, operand/result width (IEEE-754 single)
- TIMEOUT, 255, max cycles from request accept to result transfer; ≥4
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  host request valid
- req_ready  out  1  master idle, request accepted when req_valid && req_ready
- req_a, req_b  in  WIDTH  operands, sampled at accept
- input_a  out  WIDTH  operand A to unit
- input_a_stb  out  1  operand A strobe
- input_a_ack  in  1  unit ready for A
- input_b  out  WIDTH  operand B to unit
- input_b_stb  out  1  operand B strobe
- input_b_ack  in  1  unit ready for B
- output_z  in  WIDTH  result from unit
- output_z_stb  in  1  result strobe
- output_z_ack  out  1  master ready for result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host consumes response
- rsp_z  out  WIDTH  captured result (0 on timeout)
- rsp_timeout  out  1  response is a timeout
- txn_count  out  16  completed non-timeout transactions, wraps 0xFFFF→0

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RESP. req_ready = (state==IDLE), combinational.
- IDLE: on accept, latch req_a→input_a and req_b→input_b, clear timer, set input_a_stb, go to SEND_A.
- Transfer rule (all three channels): a word moves on the rising edge where strobe and ack are both 1.
- SEND_A: on A transfer, clear input_a_stb, set input_b_stb, go to SEND_B.
- SEND_B: on B transfer, clear input_b_stb, set output_z_ack, go to WAIT_Z.
- WAIT_Z: on Z transfer, rsp_z←output_z, rsp_timeout←0, clear output_z_ack, increment txn_count, set rsp_valid, go to RESP.
- Timer: increments each cycle in SEND_A/SEND_B/WAIT_Z. At the edge where the timer equals TIMEOUT−1 with no transfer completing the current state, clear all strobes/acks, rsp_z←0, rsp_timeout←1, set rsp_valid, go to RESP. A transfer on that same edge takes priority over the timeout.
- RESP: hold rsp_valid/rsp_z/rsp_timeout until rsp_ready is 1 at an edge, then clear rsp_valid and go to IDLE. rsp_z/rsp_timeout hold their values until the next response.
- input_a/input_b stay stable from accept until the next accept.
- At most one strobe/ack output is high at any time.

## Timing
- Reset (rst=0, asynchronous): state IDLE; req_ready=1. Reset value is 0 for input_a, input_b, all strobes, output_z_ack, rsp_valid, rsp_z, rsp_timeout, txn_count, and the timer.
- Reset mid-transaction abandons it with no response. The unit is reset by the same rst.
- Best case, with acks/stb already high: accept at edge E0. input_a_stb is high in cycle E0→E1 and A transfers at E1. B transfers at E2. Z transfers at E3. rsp_valid is high after E3. That is 3 edges from accept to response.
- If rsp_ready is already 1, RESP lasts one cycle and req_ready returns at the following cycle. There is no overlap of transactions.
- A late ack/stb simply extends the current state cycle by cycle, up to the timeout.

## Test plan
- Basic add: req_a=0x417C0000 (15.75), req_b=0x40E80000 (7.25), adder instance, rsp_ready=1 → rsp_z=0x41B80000 (23.0), rsp_timeout=0, txn_count=1.
- Ordering: input_b_ack held high from reset, input_a_ack delayed 5 cycles → input_b_stb never rises before the A transfer. Strobes are never high simultaneously, and input_a/input_b are stable throughout.
- Timeout: stub unit whose output_z_stb stays 0, TIMEOUT=16 → rsp_valid rises exactly 16 cycles after accept, with rsp_timeout=1, rsp_z=0, txn_count unchanged, and all strobes/acks 0.
- Timeout boundary: output_z_stb rises on the edge where the timer equals TIMEOUT−1 → normal response with rsp_timeout=0.
- Back-pressure: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_z stay stable and req_ready=0. Release → IDLE next cycle, and a second request (1.0+1.0) yields 0x40000000.
- Reset mid-op: assert rst in WAIT_Z → all outputs reach reset values immediately without a clock. After release, a new request completes normally and txn_count restarts from 0.
